// File: rtl/rob.sv
// rtl/rob.sv - reorder buffer: in-order retirement of out-of-order completed instructions
//
// Circular queue of {valid, ready, pd, rd} entries. Dispatch allocates at the
// tail, the CDB marks entries ready, and the head retires once it is ready.
// Flush empties the buffer for mispredict recovery. The retirement counter
// survives flushes.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   enq_valid       dispatch allocation request (dropped while full)
//   enq_pd, enq_rd  destination physical / architectural register
//   enq_rob_idx     index the next allocation will occupy (tail)
//   full            no free entry
//   cdb_valid       completion broadcast present
//   cdb_rob_idx     entry completed by the broadcast
//   flush           discard all entries
//   commit_valid    head entry retires this cycle
//   commit_pd/rd    head entry payload
//   commit_rob_idx  head index
//   commit_order    retirement sequence number of the retiring instruction
module rob #(
  parameter int DEPTH    = 16,
  parameter int PS_WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_valid,
  input  logic [PS_WIDTH-1:0]      enq_pd,
  input  logic [4:0]               enq_rd,
  output logic [$clog2(DEPTH)-1:0] enq_rob_idx,
  output logic                     full,
  input  logic                     cdb_valid,
  input  logic [$clog2(DEPTH)-1:0] cdb_rob_idx,
  input  logic                     flush,
  output logic                     commit_valid,
  output logic [PS_WIDTH-1:0]      commit_pd,
  output logic [4:0]               commit_rd,
  output logic [$clog2(DEPTH)-1:0] commit_rob_idx,
  output logic [63:0]              commit_order
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW:0] PTR_ONE = {{IW{1'b0}}, 1'b1};

  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [DEPTH-1:0]    ready_q, ready_d;
  logic [PS_WIDTH-1:0] pd_q [DEPTH];
  logic [4:0]          rd_q [DEPTH];
  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [IW:0]         head_q, head_d;
  logic [IW:0]         tail_q, tail_d;
  logic [63:0]         order_q, order_d;

  logic [IW-1:0]       head_idx;
  logic [IW-1:0]       tail_idx;
  logic                enq_fire;

  assign head_idx = head_q[IW-1:0];
  assign tail_idx = tail_q[IW-1:0];

  // Status comes from registered pointers only: a commit in the same cycle
  // does not open a slot for an enqueue until the following cycle.
  assign full     = (head_idx == tail_idx) && (head_q[IW] != tail_q[IW]);
  assign enq_fire = enq_valid && !full && !flush;

  assign commit_valid   = valid_q[head_idx] && ready_q[head_idx];
  assign commit_pd      = pd_q[head_idx];
  assign commit_rd      = rd_q[head_idx];
  assign commit_rob_idx = head_idx;
  assign commit_order   = order_q;
  assign enq_rob_idx    = tail_idx;

  always_comb begin
    valid_d = valid_q;
    ready_d = ready_q;
    head_d  = head_q;
    tail_d  = tail_q;
    order_d = order_q;

    // A ready head retires even in a flush cycle, so the counter still advances.
    if (commit_valid) begin
      valid_d[head_idx] = 1'b0;
      head_d            = head_q + PTR_ONE;
      order_d           = order_q + 64'd1;
    end

    if (flush) begin
      valid_d = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      // Broadcasts to unallocated entries are ignored so a stale tag cannot
      // pre-mark a slot that is later reused.
      if (cdb_valid && valid_q[cdb_rob_idx]) begin
        ready_d[cdb_rob_idx] = 1'b1;
      end
      // The tail slot is never valid when not full, so this cannot collide
      // with the CDB update above or with the head clear.
      if (enq_fire) begin
        valid_d[tail_idx] = 1'b1;
        ready_d[tail_idx] = 1'b0;
        tail_d            = tail_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      ready_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      order_q <= '0;
    end else begin
      valid_q <= valid_d;
      ready_q <= ready_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      order_q <= order_d;
    end
  end

  // Payload storage: only written on allocation, cleared on reset so the
  // head outputs read zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pd_q[i] <= '0;
        rd_q[i] <= '0;
      end
    end else if (enq_fire) begin
      pd_q[tail_idx] <= enq_pd;
      rd_q[tail_idx] <= enq_rd;
    end
  end

endmodule

// File: tb/tb_rob.sv
// tb/tb_rob.sv - randomized and directed self-checking bench for rob
module tb_rob;

  localparam int DEPTH = 16;
  localparam int PSW   = 6;
  localparam int IW    = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            enq_valid;
  logic [PSW-1:0]  enq_pd;
  logic [4:0]      enq_rd;
  logic [IW-1:0]   enq_rob_idx;
  logic            full;
  logic            cdb_valid;
  logic [IW-1:0]   cdb_rob_idx;
  logic            flush;
  logic            commit_valid;
  logic [PSW-1:0]  commit_pd;
  logic [4:0]      commit_rd;
  logic [IW-1:0]   commit_rob_idx;
  logic [63:0]     commit_order;

  rob #(.DEPTH(DEPTH), .PS_WIDTH(PSW)) dut (
    .clk            (clk),
    .rst            (rst),
    .enq_valid      (enq_valid),
    .enq_pd         (enq_pd),
    .enq_rd         (enq_rd),
    .enq_rob_idx    (enq_rob_idx),
    .full           (full),
    .cdb_valid      (cdb_valid),
    .cdb_rob_idx    (cdb_rob_idx),
    .flush          (flush),
    .commit_valid   (commit_valid),
    .commit_pd      (commit_pd),
    .commit_rd      (commit_rd),
    .commit_rob_idx (commit_rob_idx),
    .commit_order   (commit_order)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: program-ordered list of live instructions.
  typedef struct {
    logic [PSW-1:0] pd;
    logic [4:0]     rd;
    bit             rdy;
    int             idx;
  } ent_t;

  ent_t            mq[$];
  int              m_tail  = 0;
  longint unsigned m_order = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    bit cv;
    cv = (mq.size() > 0) && mq[0].rdy;
    chk("full", full, 64'(mq.size() == DEPTH));
    chk("enq_rob_idx", enq_rob_idx, 64'(m_tail));
    chk("commit_valid", commit_valid, 64'(cv));
    chk("commit_order", commit_order, m_order);
    if (cv) begin
      chk("commit_pd", commit_pd, 64'(mq[0].pd));
      chk("commit_rd", commit_rd, 64'(mq[0].rd));
      chk("commit_rob_idx", commit_rob_idx, 64'(mq[0].idx));
    end
  endtask

  // Advance the model across one clock edge using the inputs being driven.
  task automatic model_update();
    bit cv;
    bit was_full;
    cv       = (mq.size() > 0) && mq[0].rdy;
    was_full = (mq.size() == DEPTH);
    if (cdb_valid && !flush) begin
      foreach (mq[i]) if (mq[i].idx == int'(cdb_rob_idx)) mq[i].rdy = 1'b1;
    end
    if (cv) begin
      void'(mq.pop_front());
      m_order++;
    end
    if (flush) begin
      mq.delete();
      m_tail = 0;
    end else if (enq_valid && !was_full) begin
      mq.push_back('{pd: enq_pd, rd: enq_rd, rdy: 1'b0, idx: m_tail});
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  task automatic step(input bit e, input int pd, input int rd,
                      input bit c, input int ci, input bit f);
    @(negedge clk);
    check_model();
    enq_valid   = e;
    enq_pd      = PSW'(pd);
    enq_rd      = 5'(rd);
    cdb_valid   = c;
    cdb_rob_idx = IW'(ci);
    flush       = f;
    @(posedge clk);
    model_update();
  endtask

  longint unsigned saved_order;

  initial begin
    rst = 1'b1; enq_valid = 0; enq_pd = 0; enq_rd = 0;
    cdb_valid = 0; cdb_rob_idx = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_full", full, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_enq_idx", enq_rob_idx, 0);
    chk("rst_commit_idx", commit_rob_idx, 0);
    chk("rst_commit_pd", commit_pd, 0);
    chk("rst_commit_rd", commit_rd, 0);
    chk("rst_commit_order", commit_order, 0);

    // Fill to full, then a dropped 17th request
    for (int i = 0; i < 16; i++) step(1, 32 + i, i + 1, 0, 0, 0);
    #1;
    chk("full_after_16", full, 1);
    chk("tail_wrapped", enq_rob_idx, 0);
    step(1, 50, 1, 0, 0, 0);
    #1;
    chk("drop_17_full", full, 1);
    chk("drop_17_tail", enq_rob_idx, 0);

    // Head ready while full: commit cycle rejects the enqueue
    step(0, 0, 0, 1, 0, 0);
    #1;
    chk("head_ready_commit", commit_valid, 1);
    step(1, 51, 2, 0, 0, 0);
    #1;
    chk("full_drops_next", full, 0);
    chk("enq_rejected_tail", enq_rob_idx, 0);
    chk("order_after_1", commit_order, 1);
    step(1, 52, 3, 0, 0, 0);
    #1;
    chk("enq_at_idx0", enq_rob_idx, 1);
    step(0, 0, 0, 0, 0, 1);

    // Out-of-order completion, in-order commit
    for (int i = 0; i < 3; i++) step(1, 10 + i, 4, 0, 0, 0);
    step(0, 0, 0, 1, 2, 0);
    #1;
    chk("no_commit_idx2_only", commit_valid, 0);
    step(0, 0, 0, 1, 0, 0);
    #1;
    chk("commit_idx0", commit_valid, 1);
    chk("commit_idx0_idx", commit_rob_idx, 0);
    chk("commit_idx0_order", commit_order, 1);
    step(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
    #1;
    chk("inorder_order_end", commit_order, 4);

    // Flush with five valid entries, fourth one ready, plus enq/cdb
    for (int i = 0; i < 5; i++) step(1, 20 + i, 6, 0, 0, 0);
    step(0, 0, 0, 1, 6, 0);
    saved_order = m_order;
    step(1, 30, 7, 1, 4, 1);
    #1;
    chk("flush_enq_idx", enq_rob_idx, 0);
    chk("flush_commit_valid", commit_valid, 0);
    chk("flush_order_kept", commit_order, saved_order);
    step(0, 0, 0, 1, 0, 0);
    #1;
    chk("flush_no_write_cdb", commit_valid, 0);

    // Flush while the head retires
    step(1, 40, 8, 0, 0, 0);
    step(1, 41, 9, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    saved_order = m_order;
    step(0, 0, 0, 0, 0, 1);
    #1;
    chk("flush_commit_counts", commit_order, saved_order + 1);

    // CDB to unallocated idx 7, later allocation starts not-ready
    step(0, 0, 0, 1, 7, 0);
    for (int i = 0; i < 8; i++) step(1, 2 + i, 10, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1, i, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    #1;
    chk("idx7_not_ready", commit_valid, 0);
    chk("idx7_head", commit_rob_idx, 7);
    step(0, 0, 0, 1, 7, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);

    // 40 pipelined enqueue/complete/commit triples across two wraps
    saved_order = m_order;
    for (int i = 0; i < 40; i++) step(1, i, i % 32, i > 0, (i + 15) % 16, 0);
    step(0, 0, 0, 1, 39 % 16, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    #1;
    chk("triples_order", commit_order, saved_order + 40);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, $urandom, $urandom,
           $urandom_range(0, 9) < 7, $urandom_range(0, DEPTH - 1),
           $urandom_range(0, 99) < 2);
    end
    step(0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rob.md
# rob

Reorder buffer for the out-of-order RV32I core. Sits between rename/dispatch and architectural retirement: dispatch allocates one entry per renamed instruction, the CDB marks entries complete out of order, and the block retires completed entries strictly in program order, feeding the retirement RAT, the free list and the RVFI order counter. It is a circular queue of `{pd, rd, ready}` entries, `ROB_DATA_WIDTH_TOP` bits wide, with a synchronous flush for mispredict recovery.

## Interface
Parameters:
- `DEPTH`, default `ROB_DEPTH_TOP` (16): number of entries; must be a power of two.
- `PS_WIDTH`, default `RAT_PS_WIDTH_TOP` (6): physical register index width.

Ports. Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `enq_valid`  in  1  dispatch requests allocation.
- `enq_pd`  in  PS_WIDTH  destination physical register.
- `enq_rd`  in  5  destination architectural register.
- `enq_rob_idx`  out  $clog2(DEPTH)  index the entry will occupy (current tail).
- `full`  out  1  no free entry; enqueue is not accepted.
- `cdb_valid`  in  1  a result broadcast is present.
- `cdb_rob_idx`  in  $clog2(DEPTH)  entry completed by the broadcast.
- `flush`  in  1  discard all entries (mispredict).
- `commit_valid`  out  1  head entry retires this cycle.
- `commit_pd`  out  PS_WIDTH  head pd.
- `commit_rd`  out  5  head rd.
- `commit_rob_idx`  out  $clog2(DEPTH)  head index.
- `commit_order`  out  64  RVFI order of the retiring instruction.

## Operation
- Storage: `DEPTH` entries of `{valid, ready, pd, rd}`; head and tail pointers of `$clog2(DEPTH)+1` bits (extra wrap bit).
- `full` = head and tail index bits equal and wrap bits differ; empty = pointers equal. Both are derived from registered pointers only.
- Enqueue: when `enq_valid && !full`, write `{valid=1, ready=0, enq_pd, enq_rd}` at tail; tail increments. `enq_valid` while `full` is dropped; no state change.
- Completion: when `cdb_valid` and entry `cdb_rob_idx` is valid, set its ready bit. A broadcast to an invalid entry is ignored.
- Commit: `commit_valid` = head entry valid and ready (combinational from registered state). When asserted, at the clock edge clear the entry's valid bit, increment head, and increment the order counter. `commit_pd`, `commit_rd` and `commit_rob_idx` always reflect the head entry. Their values are meaningful only when `commit_valid` is high.
- Order counter: 64 bits. `commit_order` equals the counter value and starts at 0.
- `rd == 0` entries commit normally; downstream logic discards them.
- Flush: clears every valid bit and every ready bit. Head and tail return to 0. The order counter is kept. Flush has priority over enqueue and CDB in the same cycle. A commit that is valid in the flush cycle still retires: the counter increments, and the flush then empties the buffer.

## Timing
- Reset: all entries are invalid; head = tail = 0. Outputs: `full`=0, `commit_valid`=0, `enq_rob_idx`=0, `commit_rob_idx`=0, `commit_pd`=0, `commit_rd`=0, `commit_order`=0.
- Enqueue is visible at the head no earlier than the next cycle. The minimum dispatch-to-commit time is 2 cycles: enqueue at edge N, CDB at edge N+1, `commit_valid` during cycle N+2.
- There is no CDB-to-commit bypass. A broadcast to the head sets ready at the edge, and `commit_valid` rises in the following cycle.
- Commit and enqueue may occur in the same cycle. When `full` is set, enqueue is still rejected even though a commit frees a slot that cycle; `full` drops in the next cycle.
- Wrap-around: pointers roll from index `DEPTH-1` to 0, and the wrap bit toggles.
- Throughput: one enqueue, one CDB update and one commit per cycle.

## Test plan
- Reset, then enqueue 16 entries (pd 32..47) → `enq_rob_idx` reads 0..15; `full`=1 after the 16th. A 17th `enq_valid` is dropped, and the tail is unchanged.
- Enqueue idx 0,1,2; CDB on idx 2, then idx 0, then idx 1 → commits occur in order 0,1,2. `commit_order` reads 0,1,2, and nothing commits before idx 0 is ready.
- Buffer full with head ready → in the commit cycle, simultaneous `enq_valid` is rejected; the next cycle has `full`=0 and enqueue is accepted at idx 0 after wrap.
- Run 40 enqueue/CDB/commit triples (two wraps) → `commit_pd` matches the enqueue order, and `commit_order` reaches 39.
- Five entries valid, idx 3 ready, assert `flush` with `enq_valid` and `cdb_valid` → the next cycle is empty: `enq_rob_idx`=0, `commit_valid`=0, and no entry is written. The order counter is unchanged unless the head was ready.
- `cdb_valid` to an unallocated idx 7 on an empty buffer → no state change. A later enqueue into idx 7 starts with ready=0.
